bch_cmd_controller: RTL and testbench

- Command sequencer between the UART receive/transmit path and the BCH encoder/decoder core.
- Takes a completed 6-byte command frame, validates it, and launches the encode or decode operation with a one-cycle start pulse.
- Waits for the codec result, guarded by a timeout, then streams a 6-byte response frame to the UART transmitter one byte at a time over a valid/ready handshake.

---
 rtl/bch_pkg.sv | 32 +++
 rtl/bch_cmd_controller_if.sv | 26 ++
 rtl/bch_rsp_serializer.sv | 59 +++++
 rtl/bch_cmd_controller.sv | 135 +++++++++++++
 tb/tb_bch_cmd_controller.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bch_pkg.sv
// Shared constants, state encoding and frame helpers for the BCH command controller.
package bch_pkg;

   localparam logic [7:0] CMD_ENC     = 8'h01;
   localparam logic [7:0] CMD_DEC     = 8'h02;
   localparam logic [7:0] FRAME_TERM  = 8'h0F;
   localparam logic [7:0] RSP_ENC     = 8'h81;
   localparam logic [7:0] RSP_DEC     = 8'h82;
   localparam logic [7:0] RSP_ERR     = 8'hEE;
   localparam logic [7:0] RSP_UNCORR  = 8'hE2;
   localparam logic [7:0] ERR_CMD     = 8'h01;
   localparam logic [7:0] ERR_TIMEOUT = 8'h02;
   localparam int         FRAME_BYTES = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_START,
      ST_WAIT,
      ST_LOAD,
      ST_SEND
   } ctrl_state_t;

   function automatic logic frame_ok(input logic [47:0] f);
      return ((f[47:40] == CMD_ENC) || (f[47:40] == CMD_DEC)) && (f[7:0] == FRAME_TERM);
   endfunction

   function automatic logic [47:0] err_rsp(input logic [7:0] code);
      return {RSP_ERR, code, 24'h00_0000, FRAME_TERM};
   endfunction

endpackage

// File: rtl/bch_cmd_controller_if.sv
// Codec launch/result signals and the byte-wide response stream toward the UART transmitter.
interface bch_cmd_controller_if #(
   parameter int DATA_W = 32
) ();

   logic              enc_start;
   logic              dec_start;
   logic [DATA_W-1:0] codec_data;
   logic              codec_done;
   logic [DATA_W-1:0] codec_result;
   logic              codec_err;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output enc_start, dec_start, codec_data, tx_data, tx_valid,
      input  codec_done, codec_result, codec_err, tx_ready
   );

   modport slave (
      input  enc_start, dec_start, codec_data, tx_data, tx_valid,
      output codec_done, codec_result, codec_err, tx_ready
   );

endinterface

// File: rtl/bch_rsp_serializer.sv
// Loads a 48-bit response word and streams it MSB byte first over valid/ready.
module bch_rsp_serializer
   import bch_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [47:0] word_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        done_o
);

   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   logic [47:0] sh_q, sh_d;
   logic [2:0]  idx_q, idx_d;
   logic        vld_q, vld_d;
   logic        xfer;

   assign xfer       = vld_q & tx_ready_i;
   assign tx_data_o  = sh_q[47:40];
   assign tx_valid_o = vld_q;
   assign done_o     = xfer && (idx_q == LAST_IDX);

   always_comb begin
      sh_d  = sh_q;
      idx_d = idx_q;
      vld_d = vld_q;
      if (load_i) begin
         sh_d  = word_i;
         idx_d = 3'd0;
         vld_d = 1'b1;
      end else if (xfer) begin
         // Shifting zeros in leaves tx_data at 0 once the frame is out.
         sh_d = {sh_q[39:0], 8'h00};
         if (idx_q == LAST_IDX) begin
            idx_d = 3'd0;
            vld_d = 1'b0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_q  <= '0;
         idx_q <= '0;
         vld_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         idx_q <= idx_d;
         vld_q <= vld_d;
      end
   end

endmodule

// File: rtl/bch_cmd_controller.sv
// Validates UART command frames, launches the BCH codec and returns a 6-byte response.
module bch_cmd_controller
   import bch_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [47:0]           frame_i,
   input  logic                  frame_ready_i,
   output logic                  busy_o,
   output logic                  drop_o,
   bch_cmd_controller_if.master  bus
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   ctrl_state_t       state_q, state_d;
   logic [47:0]       frame_q, frame_d;
   logic [47:0]       rsp_q, rsp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fr_q, fr_d;
   logic              enc_q, enc_d;
   logic              dec_q, dec_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;
   logic              rise;
   logic              ser_done;
   logic [7:0]        hdr;

   assign rise = frame_ready_i & ~fr_q;
   assign hdr  = bus.codec_err ? RSP_UNCORR :
                 (frame_q[47:40] == CMD_DEC) ? RSP_DEC : RSP_ENC;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      rsp_d   = rsp_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      fr_d    = frame_ready_i;
      enc_d   = 1'b0;
      dec_d   = 1'b0;
      drop_d  = drop_q;
      if (rise && (state_q != ST_IDLE)) drop_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               frame_d = frame_i;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (frame_ok(frame_q)) begin
               state_d = ST_START;
            end else begin
               rsp_d   = err_rsp(ERR_CMD);
               state_d = ST_LOAD;
            end
         end
         ST_START: begin
            // Start pulse and payload register together, so data is valid with the pulse.
            data_d  = frame_q[39:8];
            enc_d   = (frame_q[47:40] == CMD_ENC);
            dec_d   = (frame_q[47:40] == CMD_DEC);
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.codec_done) begin
               rsp_d   = {hdr, bus.codec_result, FRAME_TERM};
               state_d = ST_LOAD;
            end else if (cnt_q == CNT_LAST) begin
               rsp_d   = err_rsp(ERR_TIMEOUT);
               state_d = ST_LOAD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LOAD: state_d = ST_SEND;
         ST_SEND: if (ser_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         frame_q <= '0;
         rsp_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         fr_q    <= 1'b0;
         enc_q   <= 1'b0;
         dec_q   <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         rsp_q   <= rsp_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         fr_q    <= fr_d;
         enc_q   <= enc_d;
         dec_q   <= dec_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.enc_start  = enc_q;
   assign bus.dec_start  = dec_q;
   assign bus.codec_data = data_q;
   assign busy_o         = busy_q;
   assign drop_o         = drop_q;

   bch_rsp_serializer u_ser (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (state_q == ST_LOAD),
      .word_i     (rsp_q),
      .tx_data_o  (bus.tx_data),
      .tx_valid_o (bus.tx_valid),
      .tx_ready_i (bus.tx_ready),
      .done_o     (ser_done)
   );

endmodule

// File: tb/tb_bch_cmd_controller.sv
// Directed bench: expected response bytes are queued at stimulus time and popped by a TX monitor.
module tb_bch_cmd_controller;
   import bch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [47:0] frame = '0;
   logic        frame_ready = 1'b0;
   logic        busy, drop;

   bch_cmd_controller_if #(.DATA_W(32)) bus ();

   bch_cmd_controller #(.DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .frame_i       (frame),
      .frame_ready_i (frame_ready),
      .busy_o        (busy),
      .drop_o        (drop),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] sb[$];
   int         xfer_cnt = 0;
   int         enc_cnt = 0;
   int         dec_cnt = 0;
   int         exp_enc = 0;
   int         exp_dec = 0;
   bit         bp = 1'b0;
   int         rdy_ph = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] held = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ready pattern: always ready, or accept only one cycle in three.
   always @(posedge clk) begin
      #1;
      rdy_ph++;
      bus.tx_ready = bp ? (rdy_ph % 3 == 0) : 1'b1;
   end

   // TX monitor / scoreboard and start-pulse accounting.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", bus.tx_valid, 1'b1);
            chk("hold_data", bus.tx_data, held);
         end
         if (bus.enc_start || bus.dec_start) chk("start_exclusive", bus.enc_start & bus.dec_start, 1'b0);
         if (bus.enc_start) enc_cnt++;
         if (bus.dec_start) dec_cnt++;
         if (bus.tx_valid && bus.tx_ready) begin
            xfer_cnt++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_unexpected: got byte %0h with nothing expected", bus.tx_data);
            end else begin
               chk("tx_byte", bus.tx_data, sb.pop_front());
            end
         end
         stall_prev = bus.tx_valid && !bus.tx_ready;
         held       = bus.tx_data;
      end
   end

   task automatic push_rsp(input logic [47:0] w);
      for (int i = 0; i < 6; i++) sb.push_back(w[47-8*i -: 8]);
   endtask

   task automatic send_frame(input logic [47:0] f);
      @(posedge clk); #1;
      frame       = f;
      frame_ready = 1'b1;
   endtask

   task automatic expect_start(input logic [47:0] f);
      int k;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!(bus.enc_start || bus.dec_start) && k < 20);
      chk("start_latency", k, 3);
      chk("enc_start", bus.enc_start, f[47:40] == CMD_ENC);
      chk("dec_start", bus.dec_start, f[47:40] == CMD_DEC);
      chk("codec_data", bus.codec_data, f[39:8]);
      frame_ready = 1'b0;
   endtask

   task automatic codec_reply(input int dly, input logic [31:0] r, input logic e);
      repeat (dly) @(posedge clk);
      #1;
      bus.codec_done   = 1'b1;
      bus.codec_result = r;
      bus.codec_err    = e;
      @(posedge clk); #1;
      bus.codec_done = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (busy && k < 300);
      chk("idle_reached", busy, 1'b0);
      chk("sb_drained", sb.size(), 0);
      chk("enc_count", enc_cnt, exp_enc);
      chk("dec_count", dec_cnt, exp_dec);
   endtask

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;
      bus.codec_done   = 1'b0;
      bus.codec_result = '0;
      bus.codec_err    = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_enc", bus.enc_start, 1'b0);
      chk("rst_dec", bus.dec_start, 1'b0);
      chk("rst_data", bus.codec_data, 32'h0);
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop", drop, 1'b0);
      rst = 1'b0;

      // Encode
      push_rsp(48'h81_12345678_0F);
      exp_enc++;
      send_frame(48'h01_DEADBEEF_0F);
      expect_start(48'h01_DEADBEEF_0F);
      codec_reply(10, 32'h12345678, 1'b0);
      wait_idle();

      // Decode with uncorrectable error
      push_rsp(48'hE2_00000000_0F);
      exp_dec++;
      send_frame(48'h02_00000001_0F);
      expect_start(48'h02_00000001_0F);
      codec_reply(4, 32'h0, 1'b1);
      wait_idle();

      // Bad command, then bad terminator
      push_rsp(48'hEE_01_000000_0F);
      send_frame(48'h05_01020304_0F);
      wait_idle();
      frame_ready = 1'b0;
      push_rsp(48'hEE_01_000000_0F);
      send_frame(48'h01_01020304_AA);
      wait_idle();
      frame_ready = 1'b0;

      // Timeout, with a late done arriving while the response is being sent
      push_rsp(48'hEE_02_000000_0F);
      exp_enc++;
      send_frame(48'h01_00000000_0F);
      expect_start(48'h01_00000000_0F);
      k = 0;
      while (!bus.tx_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("timeout_tx_started", bus.tx_valid, 1'b1);
      codec_reply(0, 32'hFFFFFFFF, 1'b0);
      wait_idle();

      // Backpressure
      bp = 1'b1;
      push_rsp(48'h81_A5A55A5A_0F);
      exp_enc++;
      send_frame(48'h01_CAFEF00D_0F);
      expect_start(48'h01_CAFEF00D_0F);
      codec_reply(5, 32'hA5A55A5A, 1'b0);
      wait_idle();
      bp = 1'b0;

      // Second frame edge during WAIT is dropped
      chk("drop_before", drop, 1'b0);
      push_rsp(48'h82_55667788_0F);
      exp_dec++;
      send_frame(48'h02_11223344_0F);
      expect_start(48'h02_11223344_0F);
      @(posedge clk); #1;
      frame       = 48'h01_99999999_0F;
      frame_ready = 1'b1;
      @(posedge clk); #1;
      chk("drop_set", drop, 1'b1);
      codec_reply(3, 32'h55667788, 1'b0);
      wait_idle();
      frame_ready = 1'b0;
      chk("drop_sticky", drop, 1'b1);

      // Reset in SEND after two bytes
      sb.push_back(8'h81);
      sb.push_back(8'h01);
      exp_enc++;
      base = xfer_cnt;
      send_frame(48'h01_0BADF00D_0F);
      expect_start(48'h01_0BADF00D_0F);
      codec_reply(2, 32'h01020304, 1'b0);
      k = 0;
      while (xfer_cnt != base + 2 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("two_bytes_sent", xfer_cnt - base, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_enc", bus.enc_start, 1'b0);
      chk("mid_rst_dec", bus.dec_start, 1'b0);
      chk("mid_rst_data", bus.codec_data, 32'h0);
      chk("mid_rst_tx_valid", bus.tx_valid, 1'b0);
      chk("mid_rst_tx_data", bus.tx_data, 8'h0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_drop", drop, 1'b0);
      chk("mid_rst_sb", sb.size(), 0);
      rst = 1'b0;

      // Normal operation after reset
      push_rsp(48'h81_0C0FFEE0_0F);
      exp_enc++;
      send_frame(48'h01_A1B2C3D4_0F);
      expect_start(48'h01_A1B2C3D4_0F);
      codec_reply(6, 32'h0C0FFEE0, 1'b0);
      wait_idle();
      frame_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("final_tx_valid", bus.tx_valid, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
